// File: rtl/slot_arb_pkg.sv
// Shared definitions for the slot arbiter: occupancy state encoding,
// default depth/width constants and the round-robin pointer helper.
package slot_arb_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MID   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam int DEF_DEPTH = 7;
    localparam int DEF_CW    = 3;

    // Index the round-robin pointer moves to after granting requester idx.
    function automatic int rr_next(input int idx, input int nreq);
        return (idx + 1 >= nreq) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: finds the first set bit of elig_i searching
// upward from start_i with wrap-around, and returns it one-hot plus its index.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  elig_i,
    input  logic [IW-1:0] start_i,
    output logic [N-1:0]  gnt_o,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    logic [2*N-1:0] rot2;
    logic [N-1:0]   rotLow;

    // Rotate the request vector so the start position lands on bit 0.
    always_comb begin
        rot2   = {elig_i, elig_i} >> start_i;
        rotLow = rot2[N-1:0];
    end

    // Take the lowest set bit of the rotated vector and map it back.
    always_comb begin
        int sum;
        sum     = 0;
        valid_o = 1'b0;
        idx_o   = '0;
        for (int p = 0; p < N; p++) begin
            if (!valid_o && rotLow[p]) begin
                valid_o = 1'b1;
                sum     = int'(start_i) + p;
                if (sum >= N) begin
                    sum = sum - N;
                end
                idx_o   = IW'(sum);
            end
        end
        gnt_o = valid_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/slot_arbiter.sv
// Round-robin arbiter in front of a shared occupancy counter. Requesters
// raise ACQ/REL and receive one-cycle AGNT/RGNT pulses; the count, empty and
// full flags update in the same cycle as the grant.
// Optional build macro SLOT_ARB_PAIR_EN: allows one acquire and one release
// from different requesters to be granted together in the same cycle.
module slot_arbiter
    import slot_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CW    = DEF_CW
) (
    input  logic            CLK,
    input  logic            MR,
    input  logic [NREQ-1:0] ACQ,
    input  logic [NREQ-1:0] REL,
    output logic [NREQ-1:0] AGNT,
    output logic [NREQ-1:0] RGNT,
    output logic [CW-1:0]   CO,
    output logic            EF,
    output logic            FF
);

    localparam int RW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [CW-1:0]   co_q, co_d;
    logic [NREQ-1:0] agnt_q, agnt_d;
    logic [NREQ-1:0] rgnt_q, rgnt_d;
    logic [RW-1:0]   rr_q, rr_d;

    logic [NREQ-1:0] busy;
    logic            notEmpty;
    logic            notFull;

    // A requester whose grant is on the wire this cycle sits out one round.
    always_comb begin
        busy     = agnt_q | rgnt_q;
        notEmpty = (state_q != ST_EMPTY);
        notFull  = (state_q != ST_FULL);
    end

`ifdef SLOT_ARB_PAIR_EN

    logic [NREQ-1:0] acqBase, relBase;
    logic [NREQ-1:0] aGnt, rGnt;
    logic            aValid, rValid;
    logic [RW-1:0]   aIdx, rIdx;

    // Acquires and releases are searched separately; an acquire from a
    // requester that is also releasing waits, so a pair is always two requesters.
    always_comb begin
        relBase = REL & ~busy;
        acqBase = ACQ & ~REL & ~busy;
    end

    rr_pick #(.N(NREQ), .IW(RW)) u_pickAcq (
        .elig_i (acqBase),
        .start_i(rr_q),
        .gnt_o  (aGnt),
        .valid_o(aValid),
        .idx_o  (aIdx)
    );

    rr_pick #(.N(NREQ), .IW(RW)) u_pickRel (
        .elig_i (relBase),
        .start_i(rr_q),
        .gnt_o  (rGnt),
        .valid_o(rValid),
        .idx_o  (rIdx)
    );

    // Pair when both sides have a winner (count unchanged), otherwise grant
    // a lone acquire or release only if it cannot overflow or underflow.
    always_comb begin
        agnt_d = '0;
        rgnt_d = '0;
        co_d   = co_q;
        rr_d   = rr_q;
        if (aValid && rValid) begin
            agnt_d = aGnt;
            rgnt_d = rGnt;
            rr_d   = RW'(rr_next(int'((aIdx > rIdx) ? aIdx : rIdx), NREQ));
        end else if (aValid && notFull) begin
            agnt_d = aGnt;
            co_d   = co_q + CW'(1);
            rr_d   = RW'(rr_next(int'(aIdx), NREQ));
        end else if (rValid && notEmpty) begin
            rgnt_d = rGnt;
            co_d   = co_q - CW'(1);
            rr_d   = RW'(rr_next(int'(rIdx), NREQ));
        end
    end

`else

    logic [NREQ-1:0] acqElig, relElig;
    logic [NREQ-1:0] pickGnt;
    logic            pickValid;
    logic [RW-1:0]   pickIdx;

    // Release wins over acquire on the same requester; full blocks acquires
    // and empty blocks releases so the count can never wrap.
    always_comb begin
        relElig = REL & ~busy & {NREQ{notEmpty}};
        acqElig = ACQ & ~REL & ~busy & {NREQ{notFull}};
    end

    rr_pick #(.N(NREQ), .IW(RW)) u_pick (
        .elig_i (acqElig | relElig),
        .start_i(rr_q),
        .gnt_o  (pickGnt),
        .valid_o(pickValid),
        .idx_o  (pickIdx)
    );

    // Single winner per cycle; its kind decides the count direction.
    always_comb begin
        agnt_d = '0;
        rgnt_d = '0;
        co_d   = co_q;
        rr_d   = rr_q;
        if (pickValid) begin
            rr_d = RW'(rr_next(int'(pickIdx), NREQ));
            if (|(pickGnt & relElig)) begin
                rgnt_d = pickGnt;
                co_d   = co_q - CW'(1);
            end else begin
                agnt_d = pickGnt;
                co_d   = co_q + CW'(1);
            end
        end
    end

`endif

    // Occupancy state follows the count it is about to hold.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (co_d == CW'(DEPTH)) begin
                    state_d = ST_FULL;
                end else if (co_d != '0) begin
                    state_d = ST_MID;
                end
            end
            ST_MID: begin
                if (co_d == '0) begin
                    state_d = ST_EMPTY;
                end else if (co_d == CW'(DEPTH)) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (co_d == '0) begin
                    state_d = ST_EMPTY;
                end else if (co_d != CW'(DEPTH)) begin
                    state_d = ST_MID;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Register everything; reset drops any pending grant and empties the pool.
    always_ff @(posedge CLK) begin
        if (MR) begin
            state_q <= ST_EMPTY;
            co_q    <= '0;
            agnt_q  <= '0;
            rgnt_q  <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            co_q    <= co_d;
            agnt_q  <= agnt_d;
            rgnt_q  <= rgnt_d;
            rr_q    <= rr_d;
        end
    end

    assign AGNT = agnt_q;
    assign RGNT = rgnt_q;
    assign CO   = co_q;
    assign EF   = (state_q == ST_EMPTY);
    assign FF   = (state_q == ST_FULL);

endmodule

// File: tb/tb_slot_arbiter.sv
// Directed testbench for slot_arbiter with two requesters and depth 7.
// Build with SLOT_ARB_PAIR_EN defined to also cover the paired-grant scenario.
module tb_slot_arbiter;

    logic       CLK = 1'b0;
    logic       MR;
    logic [1:0] ACQ;
    logic [1:0] REL;
    logic [1:0] AGNT;
    logic [1:0] RGNT;
    logic [2:0] CO;
    logic       EF;
    logic       FF;

    int vecs        = 0;
    int miscompares = 0;

    slot_arbiter #(.NREQ(2), .DEPTH(7), .CW(3)) dut (
        .CLK (CLK),
        .MR  (MR),
        .ACQ (ACQ),
        .REL (REL),
        .AGNT(AGNT),
        .RGNT(RGNT),
        .CO  (CO),
        .EF  (EF),
        .FF  (FF)
    );

    // Free-running 10 ns clock.
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        MR  = 1'b1;
        ACQ = 2'b00;
        REL = 2'b00;
        tick;
        MR  = 1'b0;
    endtask

    task automatic test_reset;
        MR  = 1'b1;
        ACQ = 2'b11;
        REL = 2'b00;
        tick;
        vecs++;
        if (CO !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_co got %0d want 0", CO); end
        vecs++;
        if (EF !== 1'b1 || FF !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_flags got EF=%b FF=%b want EF=1 FF=0", EF, FF); end
        vecs++;
        if (AGNT !== 2'b00 || RGNT !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_grants got AGNT=%b RGNT=%b want 00 00", AGNT, RGNT); end
        MR  = 1'b0;
        ACQ = 2'b01;
        tick;
        vecs++;
        if (AGNT !== 2'b01) begin miscompares++; $display("[TB] FAIL first_acq_agnt got %b want 01", AGNT); end
        vecs++;
        if (CO !== 3'd1 || EF !== 1'b0) begin miscompares++; $display("[TB] FAIL first_acq_count got CO=%0d EF=%b want CO=1 EF=0", CO, EF); end
        ACQ = 2'b00;
        tick;
        vecs++;
        if (AGNT !== 2'b00 || CO !== 3'd1) begin miscompares++; $display("[TB] FAIL first_acq_pulse got AGNT=%b CO=%0d want 00 1", AGNT, CO); end
    endtask

    task automatic test_fill;
        logic [1:0] expA;
        do_reset;
        for (int i = 0; i < 7; i++) begin
            ACQ  = (i % 2 == 0) ? 2'b01 : 2'b10;
            expA = ACQ;
            tick;
            vecs++;
            if (AGNT !== expA || CO !== 3'(i + 1)) begin
                miscompares++;
                $display("[TB] FAIL fill_step%0d got AGNT=%b CO=%0d want AGNT=%b CO=%0d", i, AGNT, CO, expA, i + 1);
            end
        end
        vecs++;
        if (FF !== 1'b1 || EF !== 1'b0 || CO !== 3'd7) begin miscompares++; $display("[TB] FAIL fill_full got FF=%b EF=%b CO=%0d want 1 0 7", FF, EF, CO); end
        ACQ = 2'b01;
        for (int i = 0; i < 20; i++) begin
            tick;
            vecs++;
            if (AGNT !== 2'b00 || CO !== 3'd7 || FF !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL full_block%0d got AGNT=%b CO=%0d FF=%b want 00 7 1", i, AGNT, CO, FF);
            end
        end
        ACQ = 2'b00;
    endtask

    task automatic test_fairness;
        logic [1:0] expA;
        do_reset;
        ACQ = 2'b11;
        for (int i = 0; i < 7; i++) begin
            expA = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick;
            vecs++;
            if (AGNT !== expA || CO !== 3'(i + 1)) begin
                miscompares++;
                $display("[TB] FAIL fair_step%0d got AGNT=%b CO=%0d want AGNT=%b CO=%0d", i, AGNT, CO, expA, i + 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            vecs++;
            if (AGNT !== 2'b00 || FF !== 1'b1) begin miscompares++; $display("[TB] FAIL fair_full%0d got AGNT=%b FF=%b want 00 1", i, AGNT, FF); end
        end
        ACQ = 2'b00;
    endtask

    task automatic test_release_empty;
        do_reset;
        ACQ = 2'b01;
        tick;
        ACQ = 2'b00;
        tick;
        REL = 2'b10;
        tick;
        vecs++;
        if (RGNT !== 2'b10 || AGNT !== 2'b00) begin miscompares++; $display("[TB] FAIL rel_grant got RGNT=%b AGNT=%b want 10 00", RGNT, AGNT); end
        vecs++;
        if (CO !== 3'd0 || EF !== 1'b1) begin miscompares++; $display("[TB] FAIL rel_empty got CO=%0d EF=%b want 0 1", CO, EF); end
        for (int i = 0; i < 5; i++) begin
            tick;
            vecs++;
            if (RGNT !== 2'b00 || CO !== 3'd0 || EF !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL empty_block%0d got RGNT=%b CO=%0d EF=%b want 00 0 1", i, RGNT, CO, EF);
            end
        end
        REL = 2'b00;
    endtask

    task automatic test_both_on_one;
        do_reset;
        ACQ = 2'b01; tick;
        ACQ = 2'b10; tick;
        ACQ = 2'b01; tick;
        ACQ = 2'b00; tick;
        vecs++;
        if (CO !== 3'd3) begin miscompares++; $display("[TB] FAIL both_setup got CO=%0d want 3", CO); end
        ACQ = 2'b01;
        REL = 2'b01;
        tick;
        vecs++;
        if (RGNT !== 2'b01 || AGNT !== 2'b00 || CO !== 3'd2) begin
            miscompares++;
            $display("[TB] FAIL both_release got RGNT=%b AGNT=%b CO=%0d want 01 00 2", RGNT, AGNT, CO);
        end
        REL = 2'b00;
        tick;
        vecs++;
        if (AGNT !== 2'b00 || RGNT !== 2'b00 || CO !== 3'd2) begin
            miscompares++;
            $display("[TB] FAIL both_gap got AGNT=%b RGNT=%b CO=%0d want 00 00 2", AGNT, RGNT, CO);
        end
        tick;
        vecs++;
        if (AGNT !== 2'b01 || CO !== 3'd3) begin miscompares++; $display("[TB] FAIL both_acquire got AGNT=%b CO=%0d want 01 3", AGNT, CO); end
        ACQ = 2'b00;
        tick;
    endtask

    task automatic test_mid_reset;
        do_reset;
        ACQ = 2'b11;
        tick;
        tick;
        MR = 1'b1;
        tick;
        vecs++;
        if (AGNT !== 2'b00 || RGNT !== 2'b00 || CO !== 3'd0 || EF !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_reset got AGNT=%b RGNT=%b CO=%0d EF=%b want 00 00 0 1", AGNT, RGNT, CO, EF);
        end
        MR  = 1'b0;
        ACQ = 2'b00;
        tick;
    endtask

`ifdef SLOT_ARB_PAIR_EN
    task automatic test_pair;
        do_reset;
        for (int i = 0; i < 7; i++) begin
            ACQ = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick;
        end
        ACQ = 2'b00;
        tick;
        ACQ = 2'b01;
        REL = 2'b10;
        tick;
        vecs++;
        if (AGNT !== 2'b01 || RGNT !== 2'b10) begin miscompares++; $display("[TB] FAIL pair_grants got AGNT=%b RGNT=%b want 01 10", AGNT, RGNT); end
        vecs++;
        if (CO !== 3'd7 || FF !== 1'b1) begin miscompares++; $display("[TB] FAIL pair_count got CO=%0d FF=%b want 7 1", CO, FF); end
        ACQ = 2'b11;
        REL = 2'b00;
        MR  = 1'b1;
        tick;
        vecs++;
        if (CO !== 3'd0 || AGNT !== 2'b00 || RGNT !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL pair_reset got CO=%0d AGNT=%b RGNT=%b want 0 00 00", CO, AGNT, RGNT);
        end
        MR  = 1'b0;
        ACQ = 2'b00;
        tick;
    endtask
`endif

    // Run every scenario in order, then report.
    initial begin
        MR  = 1'b1;
        ACQ = 2'b00;
        REL = 2'b00;
        test_reset;
        test_fill;
        test_fairness;
        test_release_empty;
        test_both_on_one;
        test_mid_reset;
`ifdef SLOT_ARB_PAIR_EN
        test_pair;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
